// File: rtl/dmc_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmc_decode_pkg
// Description : Shared types and constants for the DMC receive-lane frame
//               sequencer (state encoding, error codes).
// Revision    : 1.0 - initial release
// ============================================================================
package dmc_decode_pkg;

    // One-hot sequencer state encoding
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_FLUSH     = 6'b000010,
        ST_SYNC_HUNT = 6'b000100,
        ST_DATA      = 6'b001000,
        ST_DONE      = 6'b010000,
        ST_ERR       = 6'b100000
    } dmc_seq_state_e;

    // Values reported on err_code
    localparam logic [1:0] DMC_ERR_NONE    = 2'd0;
    localparam logic [1:0] DMC_ERR_EARLY   = 2'd1;
    localparam logic [1:0] DMC_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] DMC_ERR_ABORT   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dmc_decode_seq_sync_hunt.sv
`default_nettype none
// ============================================================================
// Module      : dmc_sync_hunt
// Description : Saturating run-length counter of consecutive sync=1 bits.
//               match is asserted combinationally on the strobe that makes
//               the run reach max(sync_len,1).
// Revision    : 1.0 - initial release
// ============================================================================
module dmc_sync_hunt #(
    parameter int SYNC_LEN_W = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  bit_stb,
    input  logic                  sync_bit,
    input  logic [SYNC_LEN_W-1:0] sync_len,
    output logic                  match
);

    logic [SYNC_LEN_W-1:0] r_run;
    logic [SYNC_LEN_W-1:0] w_run_inc;
    logic [SYNC_LEN_W-1:0] w_target;

    // A zero length would match before any bit; treat it as one
    assign w_target  = (sync_len == '0) ? SYNC_LEN_W'(1) : sync_len;
    assign w_run_inc = (r_run == '1) ? r_run : r_run + SYNC_LEN_W'(1);
    assign match     = bit_stb && sync_bit && (w_run_inc >= w_target);

    // Run counter: count sync=1 strobes, restart on a sync=0 strobe
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_run <= '0;
        end else if (clr) begin
            r_run <= '0;
        end else if (bit_stb) begin
            r_run <= sync_bit ? w_run_inc : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmc_decode_seq.sv
`default_nettype none
// ============================================================================
// Module      : dmc_decode_seq
// Description : Frame sequencer for one DMC receive lane. Flushes the
//               decoder, hunts for a sync run, counts data bits and reports
//               frame completion or error. All outputs are registered.
//               Optional macro DMC_DECODE_SEQ_TIMEOUT_EN adds an inter-bit
//               timeout check (err_code 2).
// Revision    : 1.0 - initial release
// ============================================================================
module dmc_decode_seq
    import dmc_decode_pkg::*;
#(
    parameter int SYNC_LEN_W = 6,
    parameter int BIT_CNT_W  = 10,
    parameter int FLUSH_CYC  = 2,
    parameter int TIMEOUT_W  = 12
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SYNC_LEN_W-1:0] sync_len,
    input  logic [BIT_CNT_W-1:0]  data_len,
    input  logic [TIMEOUT_W-1:0]  timeout_cyc,
    input  logic                  dec_bit_stb,
    input  logic                  dec_sync_o,
    input  logic                  dec_data_o,
    input  logic                  dec_early_receive_done,
    output logic                  dec_enable,
    output logic                  dec_clk_or_data,
    output logic                  dec_receive_line_rst_n,
    output logic                  rx_bit,
    output logic                  rx_bit_vld,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [BIT_CNT_W-1:0]  rx_bit_cnt
);

    // FLUSH_CYC below 1 still spends one cycle in FLUSH
    localparam int c_flush_w = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'((FLUSH_CYC > 1) ? FLUSH_CYC - 1 : 0);

    dmc_seq_state_e        r_state;
    dmc_seq_state_e        w_state_nxt;
    logic [c_flush_w-1:0]  r_flush_cnt;
    logic [1:0]            w_err_nxt;
    logic [BIT_CNT_W-1:0]  w_cnt_nxt;
    logic [BIT_CNT_W-1:0]  w_cnt_inc;
    logic                  w_take_bit;
    logic                  w_sync_match;
    logic                  w_timeout;

    assign w_cnt_inc = (rx_bit_cnt == '1) ? rx_bit_cnt : rx_bit_cnt + BIT_CNT_W'(1);

    dmc_sync_hunt #(
        .SYNC_LEN_W (SYNC_LEN_W)
    ) u_sync_hunt (
        .clk_i    (clk_i),
        .reset_n  (reset_n),
        .clr      (r_state != ST_SYNC_HUNT),
        .bit_stb  (dec_bit_stb && (r_state == ST_SYNC_HUNT)),
        .sync_bit (dec_sync_o),
        .sync_len (sync_len),
        .match    (w_sync_match)
    );

`ifdef DMC_DECODE_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic                 w_to_run;

    assign w_to_run  = (r_state == ST_SYNC_HUNT) || (r_state == ST_DATA);
    assign w_timeout = w_to_run && (timeout_cyc != '0) && (r_to_cnt >= timeout_cyc);

    // Inter-bit cycle counter: reload on strobe or state change, else saturate up
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_run || dec_bit_stb || (w_state_nxt != r_state)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^timeout_cyc;
    assign w_timeout        = 1'b0;
`endif

    // Next-state, error code and bit-count decode; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = err_code;
        w_cnt_nxt   = rx_bit_cnt;
        w_take_bit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ST_FLUSH;
                    w_err_nxt   = DMC_ERR_NONE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == c_flush_last) begin
                    w_state_nxt = ST_SYNC_HUNT;
                end
            end
            ST_SYNC_HUNT: begin
                if (dec_early_receive_done) begin
                    w_state_nxt = ST_ERR;
                    w_err_nxt   = DMC_ERR_EARLY;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                    w_err_nxt   = DMC_ERR_TIMEOUT;
                end else if (w_sync_match) begin
                    w_state_nxt = (data_len == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (dec_early_receive_done) begin
                    w_state_nxt = ST_ERR;
                    w_err_nxt   = DMC_ERR_EARLY;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                    w_err_nxt   = DMC_ERR_TIMEOUT;
                end else if (dec_bit_stb) begin
                    w_take_bit = 1'b1;
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == data_len) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = DMC_ERR_ABORT;
            w_cnt_nxt   = rx_bit_cnt;
            w_take_bit  = 1'b0;
        end
    end

    // State register and registered outputs decoded from the next state
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_state                <= ST_IDLE;
            r_flush_cnt            <= '0;
            dec_enable             <= 1'b0;
            dec_clk_or_data        <= 1'b1;
            dec_receive_line_rst_n <= 1'b1;
            rx_bit                 <= 1'b0;
            rx_bit_vld             <= 1'b0;
            busy                   <= 1'b0;
            frame_done             <= 1'b0;
            frame_err              <= 1'b0;
            err_code               <= DMC_ERR_NONE;
            rx_bit_cnt             <= '0;
        end else begin
            r_state                <= w_state_nxt;
            r_flush_cnt            <= ((r_state == ST_FLUSH) && (w_state_nxt == ST_FLUSH))
                                      ? r_flush_cnt + c_flush_w'(1) : '0;
            dec_enable             <= (w_state_nxt == ST_SYNC_HUNT) || (w_state_nxt == ST_DATA);
            dec_clk_or_data        <= (w_state_nxt != ST_DATA);
            dec_receive_line_rst_n <= (w_state_nxt != ST_FLUSH);
            busy                   <= (w_state_nxt != ST_IDLE);
            frame_done             <= (w_state_nxt == ST_DONE);
            frame_err              <= (w_state_nxt == ST_ERR);
            rx_bit_vld             <= w_take_bit;
            if (w_take_bit) begin
                rx_bit <= dec_data_o;
            end
            err_code               <= w_err_nxt;
            rx_bit_cnt             <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmc_decode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmc_decode_seq
// Description : Directed self-checking bench for dmc_decode_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmc_decode_seq;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [5:0]  sync_len;
    logic [9:0]  data_len;
    logic [11:0] timeout_cyc;
    logic        dec_bit_stb;
    logic        dec_sync_o;
    logic        dec_data_o;
    logic        dec_early_receive_done;
    logic        dec_enable;
    logic        dec_clk_or_data;
    logic        dec_receive_line_rst_n;
    logic        rx_bit;
    logic        rx_bit_vld;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [9:0]  rx_bit_cnt;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          vld_cnt = 0;
    logic [15:0] rx_shift = '0;

    always #5 clk_i = ~clk_i;

    dmc_decode_seq #(
        .SYNC_LEN_W (6),
        .BIT_CNT_W  (10),
        .FLUSH_CYC  (2),
        .TIMEOUT_W  (12)
    ) dut (
        .clk_i                  (clk_i),
        .reset_n                (reset_n),
        .start                  (start),
        .abort                  (abort),
        .sync_len               (sync_len),
        .data_len               (data_len),
        .timeout_cyc            (timeout_cyc),
        .dec_bit_stb            (dec_bit_stb),
        .dec_sync_o             (dec_sync_o),
        .dec_data_o             (dec_data_o),
        .dec_early_receive_done (dec_early_receive_done),
        .dec_enable             (dec_enable),
        .dec_clk_or_data        (dec_clk_or_data),
        .dec_receive_line_rst_n (dec_receive_line_rst_n),
        .rx_bit                 (rx_bit),
        .rx_bit_vld             (rx_bit_vld),
        .busy                   (busy),
        .frame_done             (frame_done),
        .frame_err              (frame_err),
        .err_code               (err_code),
        .rx_bit_cnt             (rx_bit_cnt)
    );

    // Pulse and data-stream monitor, sampled on the falling edge
    always @(negedge clk_i) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
        if (rx_bit_vld) begin
            vld_cnt  <= vld_cnt + 1;
            rx_shift <= {rx_shift[14:0], rx_bit};
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic s, input logic d);
        dec_bit_stb = 1'b1;
        dec_sync_o  = s;
        dec_data_o  = d;
        step();
        dec_bit_stb = 1'b0;
        dec_sync_o  = 1'b0;
        dec_data_o  = 1'b0;
    endtask

    // start pulse followed by the two FLUSH cycles; returns in SYNC_HUNT
    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if ({dec_enable, dec_clk_or_data, dec_receive_line_rst_n, rx_bit, rx_bit_vld, busy, frame_done, frame_err} !== 8'b01100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 01100000",
                     {dec_enable, dec_clk_or_data, dec_receive_line_rst_n, rx_bit, rx_bit_vld, busy, frame_done, frame_err});
        end
        checks++;
        if (err_code !== 2'd0 || rx_bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset_regs: err_code=%0d cnt=%0d expected 0 0", err_code, rx_bit_cnt);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_good_frame();
        int d0;
        int v0;
        logic [7:0] pat;
        pat      = 8'b10110010;
        sync_len = 6'd4;
        data_len = 10'd8;
        d0 = done_cnt;
        v0 = vld_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, dec_enable, dec_receive_line_rst_n} !== 3'b100) begin
            errors++;
            $display("FAIL flush_first: busy/en/rst_n=%b expected 100", {busy, dec_enable, dec_receive_line_rst_n});
        end
        step();
        checks++;
        if ({busy, dec_enable, dec_receive_line_rst_n} !== 3'b100) begin
            errors++;
            $display("FAIL flush_second: busy/en/rst_n=%b expected 100", {busy, dec_enable, dec_receive_line_rst_n});
        end
        step();
        checks++;
        if ({busy, dec_enable, dec_clk_or_data, dec_receive_line_rst_n} !== 4'b1111) begin
            errors++;
            $display("FAIL hunt_entry: busy/en/cod/rst_n=%b expected 1111",
                     {busy, dec_enable, dec_clk_or_data, dec_receive_line_rst_n});
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (dec_clk_or_data !== 1'b1) begin
            errors++;
            $display("FAIL sync_three: clk_or_data=%b expected 1", dec_clk_or_data);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if ({dec_enable, dec_clk_or_data} !== 2'b10) begin
            errors++;
            $display("FAIL data_entry: en/cod=%b expected 10", {dec_enable, dec_clk_or_data});
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b0, pat[i]);
        end
        checks++;
        if ({frame_done, dec_enable, rx_bit_vld} !== 3'b101) begin
            errors++;
            $display("FAIL done_state: done/en/vld=%b expected 101", {frame_done, dec_enable, rx_bit_vld});
        end
        checks++;
        if (rx_bit_cnt !== 10'd8) begin
            errors++;
            $display("FAIL good_cnt: rx_bit_cnt=%0d expected 8", rx_bit_cnt);
        end
        step();
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL good_idle: busy=%b done=%b expected 0 0", busy, frame_done);
        end
        checks++;
        if (rx_shift[7:0] !== pat || (vld_cnt - v0) !== 8) begin
            errors++;
            $display("FAIL good_stream: bits=%b count=%0d expected %b 8", rx_shift[7:0], vld_cnt - v0, pat);
        end
        checks++;
        if ((done_cnt - d0) !== 1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL good_pulse: done pulses=%0d err_code=%0d expected 1 0", done_cnt - d0, err_code);
        end
    endtask

    task automatic test_broken_sync();
        sync_len = 6'd4;
        data_len = 10'd2;
        start_frame();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (dec_clk_or_data !== 1'b1) begin
            errors++;
            $display("FAIL broken_sync_6: clk_or_data=%b expected 1", dec_clk_or_data);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (dec_clk_or_data !== 1'b0) begin
            errors++;
            $display("FAIL broken_sync_7: clk_or_data=%b expected 0", dec_clk_or_data);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        checks++;
        if (frame_done !== 1'b1 || rx_bit_cnt !== 10'd2) begin
            errors++;
            $display("FAIL broken_done: done=%b cnt=%0d expected 1 2", frame_done, rx_bit_cnt);
        end
        step();
    endtask

    task automatic test_early_done();
        sync_len = 6'd1;
        data_len = 10'd8;
        start_frame();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        dec_early_receive_done = 1'b1;
        send_bit(1'b0, 1'b1);
        dec_early_receive_done = 1'b0;
        checks++;
        if ({frame_err, rx_bit_vld, dec_enable} !== 3'b100) begin
            errors++;
            $display("FAIL early_err: err/vld/en=%b expected 100", {frame_err, rx_bit_vld, dec_enable});
        end
        checks++;
        if (err_code !== 2'd1 || rx_bit_cnt !== 10'd2) begin
            errors++;
            $display("FAIL early_code: err_code=%0d cnt=%0d expected 1 2", err_code, rx_bit_cnt);
        end
        step();
        checks++;
        if (busy !== 1'b0 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL early_hold: busy=%b err_code=%0d expected 0 1", busy, err_code);
        end
    endtask

    task automatic test_abort();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, dec_receive_line_rst_n} !== 2'b01 || err_code !== 2'd1 || rx_bit_cnt !== 10'd2) begin
            errors++;
            $display("FAIL abort_idle: busy/rst_n=%b err_code=%0d cnt=%0d expected 01 1 2",
                     {busy, dec_receive_line_rst_n}, err_code, rx_bit_cnt);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err_code !== 2'd0 || rx_bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL start_clear: busy=%b err_code=%0d cnt=%0d expected 1 0 0", busy, err_code, rx_bit_cnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({frame_err, busy, dec_enable, dec_receive_line_rst_n} !== 4'b1101 || err_code !== 2'd3) begin
            errors++;
            $display("FAIL abort_flush: err/busy/en/rst_n=%b err_code=%0d expected 1101 3",
                     {frame_err, busy, dec_enable, dec_receive_line_rst_n}, err_code);
        end
        step();
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'd3) begin
            errors++;
            $display("FAIL abort_idle_ret: busy=%b err=%b err_code=%0d expected 0 0 3", busy, frame_err, err_code);
        end
    endtask

    task automatic test_back_to_back();
        sync_len = 6'd0;
        data_len = 10'd0;
        start_frame();
        send_bit(1'b1, 1'b0);
        checks++;
        if (frame_done !== 1'b1 || rx_bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b cnt=%0d expected 1 0", frame_done, rx_bit_cnt);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, dec_receive_line_rst_n} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_start: busy/rst_n=%b expected 10", {busy, dec_receive_line_rst_n});
        end
        step();
        step();
        send_bit(1'b0, 1'b0);
        checks++;
        if (frame_done !== 1'b0 || dec_clk_or_data !== 1'b1) begin
            errors++;
            $display("FAIL zero_sync_nomatch: done=%b cod=%b expected 0 1", frame_done, dec_clk_or_data);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b expected 1", frame_done);
        end
        step();
    endtask

    task automatic test_timeout();
        sync_len = 6'd1;
        data_len = 10'd3;
`ifdef DMC_DECODE_SEQ_TIMEOUT_EN
        timeout_cyc = 12'd20;
        start_frame();
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 19; i++) step();
        send_bit(1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1 || frame_err !== 1'b0 || err_code !== 2'd0 || rx_bit_cnt !== 10'd1) begin
            errors++;
            $display("FAIL timeout_19: busy=%b err=%b code=%0d cnt=%0d expected 1 0 0 1",
                     busy, frame_err, err_code, rx_bit_cnt);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (busy !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b err=%b expected 1 0", busy, frame_err);
        end
        step();
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL timeout_fire: err=%b code=%0d expected 1 2", frame_err, err_code);
        end
        step();
`else
        timeout_cyc = 12'd3;
        start_frame();
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (busy !== 1'b1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL timeout_ignored: busy=%b code=%0d expected 1 0", busy, err_code);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || rx_bit_cnt !== 10'd3) begin
            errors++;
            $display("FAIL slow_frame: done=%b cnt=%0d expected 1 3", frame_done, rx_bit_cnt);
        end
        step();
`endif
        timeout_cyc = 12'd0;
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        sync_len = 6'd2;
        data_len = 10'd4;
        start_frame();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        d0 = done_cnt;
        reset_n = 1'b0;
        send_bit(1'b0, 1'b1);
        checks++;
        if ({dec_enable, dec_clk_or_data, dec_receive_line_rst_n, rx_bit, rx_bit_vld, busy, frame_done, frame_err} !== 8'b01100000) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 01100000",
                     {dec_enable, dec_clk_or_data, dec_receive_line_rst_n, rx_bit, rx_bit_vld, busy, frame_done, frame_err});
        end
        checks++;
        if (err_code !== 2'd0 || rx_bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL midreset_regs: err_code=%0d cnt=%0d expected 0 0", err_code, rx_bit_cnt);
        end
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if ((done_cnt - d0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nopulse: done pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
        end
    endtask

    initial begin
        reset_n                = 1'b0;
        start                  = 1'b0;
        abort                  = 1'b0;
        sync_len               = 6'd4;
        data_len               = 10'd8;
        timeout_cyc            = 12'd0;
        dec_bit_stb            = 1'b0;
        dec_sync_o             = 1'b0;
        dec_data_o             = 1'b0;
        dec_early_receive_done = 1'b0;
        test_reset();
        test_good_frame();
        test_broken_sync();
        test_early_done();
        test_abort();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
